aes_byte_sequencer: RTL and testbench

AES_BYTE_SEQUENCER -- requirements
Module: aes_byte_sequencer

---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_phase_counter.sv | 31 +++
 rtl/aes_byte_sequencer.sv | 107 ++++++++++
 tb/tb_aes_byte_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: phase encoding, block size and default sequencing
// parameters used by the byte sequencer and the encrypt datapath.
package aes_pkg;

   localparam int BLOCK_BYTES    = 16;
   localparam int DEF_NUM_ROUNDS = 10;
   localparam int DEF_SR_LAT     = 13;
   localparam int DEF_MC_LAT     = 4;
   localparam int CNT_W          = 6;
   localparam int ROUND_W        = 4;

   typedef enum logic [2:0] {
      PH_IDLE       = 3'd0,
      PH_LOAD_XOR   = 3'd1,
      PH_SUBBYTE    = 3'd2,
      PH_SHIFTROWS  = 3'd3,
      PH_MIXCOLUMNS = 3'd4,
      PH_XOR_RK     = 3'd5,
      PH_DONE       = 3'd6
   } phase_e;

endpackage

// File: rtl/aes_phase_counter.sv
// Cycle counter for one sequencer phase: clears to zero, holds while frozen,
// wraps by itself and flags the last cycle of a phase of length len.
module aes_phase_counter
   import aes_pkg::*;
(
   input  logic             clock,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             hold,
   input  logic [CNT_W-1:0] len,
   output logic [CNT_W-1:0] cnt,
   output logic             last
);

   assign last = (cnt == len - 1'b1);

   // NOTE: non-blocking assignments for all sequential state, so every flop
   // samples values from before the edge regardless of block ordering.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (hold) begin
         cnt <= cnt;
      end else if (clear || last) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/aes_byte_sequencer.sv
// Byte-serial AES encrypt control: walks LOAD_XOR and the per-round phases,
// and decodes datapath strobes from the registered phase, cycle and round.
module aes_byte_sequencer
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
   parameter int SR_LAT     = DEF_SR_LAT,
   parameter int MC_LAT     = DEF_MC_LAT
) (
   input  logic               clock,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stall,
   output logic [2:0]         phase,
   output logic [CNT_W-1:0]   cnt,
   output logic [ROUND_W-1:0] round,
   output logic               shift_en,
   output logic               key_rd,
   output logic               wr_sel,
   output logic               mc_en,
   output logic               busy,
   output logic               done
);

   localparam logic [CNT_W-1:0]   BLK_LEN    = CNT_W'(BLOCK_BYTES);
   localparam logic [CNT_W-1:0]   SR_LEN     = CNT_W'(BLOCK_BYTES + SR_LAT);
   localparam logic [CNT_W-1:0]   MC_LEN     = CNT_W'(BLOCK_BYTES + MC_LAT);
   localparam logic [CNT_W-1:0]   SR_WR      = CNT_W'(SR_LAT);
   localparam logic [CNT_W-1:0]   MC_WR      = CNT_W'(MC_LAT);
   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

   phase_e           state;
   logic [CNT_W-1:0] len;
   logic             last;
   logic             advance;

   // NOTE: every variable written in always_comb gets a default first, so
   // no latch is inferred for unlisted phases.
   always_comb begin
      len = BLK_LEN;
      case (state)
         PH_SHIFTROWS:     len = SR_LEN;
         PH_MIXCOLUMNS:    len = MC_LEN;
         PH_IDLE, PH_DONE: len = CNT_W'(1);
         default:          len = BLK_LEN;
      endcase
   end

   assign advance = last && !stall;

   aes_phase_counter u_counter (
      .clock (clock),
      .rst_n (rst_n),
      .clear ((state == PH_IDLE) || (state == PH_DONE)),
      .hold  (stall && (state != PH_IDLE)),
      .len   (len),
      .cnt   (cnt),
      .last  (last)
   );

   // Start is only looked at in IDLE; everything else waits for the phase end.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state <= PH_IDLE;
         round <= '0;
      end else if (state == PH_IDLE) begin
         if (start) begin
            state <= PH_LOAD_XOR;
            round <= '0;
         end
      end else if (advance) begin
         case (state)
            PH_LOAD_XOR: begin
               state <= PH_SUBBYTE;
               round <= round + 1'b1;
            end
            PH_SUBBYTE:    state <= PH_SHIFTROWS;
            PH_SHIFTROWS:  state <= (round == LAST_ROUND) ? PH_XOR_RK : PH_MIXCOLUMNS;
            PH_MIXCOLUMNS: state <= PH_XOR_RK;
            PH_XOR_RK: begin
               if (round == LAST_ROUND) begin
                  state <= PH_DONE;
               end else begin
                  state <= PH_SUBBYTE;
                  round <= round + 1'b1;
               end
            end
            default:       state <= PH_IDLE;
         endcase
      end
   end

   assign phase    = state;
   assign busy     = (state != PH_IDLE);
   assign done     = (state == PH_DONE) && !stall;
   assign shift_en = busy && (state != PH_DONE) && !stall;
   assign key_rd   = ((state == PH_LOAD_XOR) || (state == PH_XOR_RK)) && !stall;

   // The first cycles of SHIFTROWS/MIXCOLUMNS only fill their pipelines.
   assign wr_sel = (state == PH_LOAD_XOR) || (state == PH_SUBBYTE) || (state == PH_XOR_RK)
                || ((state == PH_SHIFTROWS)  && (cnt >= SR_WR))
                || ((state == PH_MIXCOLUMNS) && (cnt >= MC_WR));

   // Accumulation restarts at each column boundary of the 16-byte state.
   assign mc_en = (state == PH_MIXCOLUMNS) && ((cnt >= BLK_LEN) || (cnt[1:0] != 2'b00));

endmodule

// File: tb/tb_aes_byte_sequencer.sv
// Randomised and directed bench for aes_byte_sequencer against a schedule-based
// model of the phase sequence.
module tb_aes_byte_sequencer;

   localparam int NR  = 10;
   localparam int SRL = 13;
   localparam int MCL = 4;

   logic       clock;
   logic       rst_n;
   logic       start;
   logic       stall;
   logic [2:0] phase;
   logic [5:0] cnt;
   logic [3:0] round;
   logic       shift_en, key_rd, wr_sel, mc_en, busy, done;

   int n_checks = 0;
   int n_errors = 0;

   aes_byte_sequencer #(.NUM_ROUNDS(NR), .SR_LAT(SRL), .MC_LAT(MCL)) dut (
      .clock    (clock),
      .rst_n    (rst_n),
      .start    (start),
      .stall    (stall),
      .phase    (phase),
      .cnt      (cnt),
      .round    (round),
      .shift_en (shift_en),
      .key_rd   (key_rd),
      .wr_sel   (wr_sel),
      .mc_en    (mc_en),
      .busy     (busy),
      .done     (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the whole encryption as a flat list of (phase, length, round) segments.
   int seg_ph[64];
   int seg_len[64];
   int seg_rnd[64];
   int nseg = 0;

   task automatic add_seg(input int ph, input int len, input int rnd);
      seg_ph[nseg]  = ph;
      seg_len[nseg] = len;
      seg_rnd[nseg] = rnd;
      nseg++;
   endtask

   task automatic build_schedule();
      add_seg(1, 16, 0);
      for (int r = 1; r <= NR; r++) begin
         add_seg(2, 16, r);
         add_seg(3, 16 + SRL, r);
         if (r < NR) add_seg(4, 16 + MCL, r);
         add_seg(5, 16, r);
      end
      add_seg(6, 1, NR);
   endtask

   bit m_act = 0;
   int m_idx = 0;
   int m_off = 0;
   int m_rnd = 0;

   always @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         m_act <= 0;
         m_idx <= 0;
         m_off <= 0;
         m_rnd <= 0;
      end else if (!m_act) begin
         if (start) begin
            m_act <= 1;
            m_idx <= 0;
            m_off <= 0;
            m_rnd <= seg_rnd[0];
         end
      end else if (!stall) begin
         if (m_off + 1 == seg_len[m_idx]) begin
            m_off <= 0;
            if (m_idx + 1 == nseg) begin
               m_act <= 0;
               m_idx <= 0;
            end else begin
               m_idx <= m_idx + 1;
               m_rnd <= seg_rnd[m_idx + 1];
            end
         end else begin
            m_off <= m_off + 1;
         end
      end
   end

   // Every cycle: outputs must follow the model's phase/cycle/round.
   always @(negedge clock) begin
      int ph;
      ph = m_act ? seg_ph[m_idx] : 0;
      check("phase", int'(phase), ph);
      check("cnt", int'(cnt), m_off);
      check("round", int'(round), m_rnd);
      check("busy", int'(busy), int'(ph != 0));
      check("done", int'(done), int'(ph == 6 && !stall));
      check("shift_en", int'(shift_en), int'(ph != 0 && ph != 6 && !stall));
      check("key_rd", int'(key_rd), int'((ph == 1 || ph == 5) && !stall));
      check("wr_sel", int'(wr_sel), int'(ph == 1 || ph == 2 || ph == 5
                                        || (ph == 3 && m_off >= SRL)
                                        || (ph == 4 && m_off >= MCL)));
      check("mc_en", int'(mc_en), int'(ph == 4 && !(m_off < 16 && m_off % 4 == 0)));
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic wait_for(input string name, input int ph, input int rnd, input int c,
                           inout int n);
      int g = 0;
      while (!(int'(phase) == ph && int'(round) == rnd && int'(cnt) == c) && g < 2000) begin
         tick();
         n++;
         g++;
      end
      check(name, int'(g < 2000), 1);
   endtask

   task automatic run_to_done(inout int n);
      int g = 0;
      while (!done && g < 2000) begin
         tick();
         n++;
         g++;
      end
   endtask

   logic [19:0] mc_pat = 20'hFEEEE;
   logic [19:0] wr_pat = 20'hFFFF0;

   initial begin
      int n, keys, prev, nseq, dones, done_at;
      int seq[5];
      build_schedule();
      rst_n = 1'b0;
      start = 1'b0;
      stall = 1'b0;
      tick();
      tick();
      check("reset_phase", int'(phase), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_round", int'(round), 0);
      rst_n = 1'b1;

      // Full run, start on the first edge after reset release.
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0; keys = 0; prev = 0; nseq = 0;
      while (!done && n < 2000) begin
         if (key_rd) keys++;
         if (int'(phase) != prev) begin
            if (nseq < 5) seq[nseq] = int'(phase);
            nseq++;
            if (prev == 3 && round == 4'(NR)) check("final_sr_next", int'(phase), 5);
         end
         if (phase == 3'd4 && round == 4'd3) begin
            check("r3_mc_en", int'(mc_en), int'(mc_pat[cnt]));
            check("r3_wr_sel", int'(wr_sel), int'(wr_pat[cnt]));
         end
         prev = int'(phase);
         tick();
         n++;
      end
      check("run1_done_cycle", n, 806);
      check("run1_key_rd_total", keys, 176);
      check("seq0", seq[0], 1);
      check("seq1", seq[1], 2);
      check("seq2", seq[2], 3);
      check("seq3", seq[3], 4);
      check("seq4", seq[4], 5);
      check("final_round", int'(round), 10);
      tick();
      check("busy_after_done", int'(busy), 0);
      check("round_held", int'(round), 10);

      // Five-cycle stall in SHIFTROWS.
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      wait_for("reach_sr7", 3, 1, 7, n);
      stall = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("stall_cnt_hold", int'(cnt), 7);
         check("stall_shift_off", int'(shift_en), 0);
         tick();
         n++;
      end
      stall = 1'b0;
      check("cnt_after_stall", int'(cnt), 7);
      run_to_done(n);
      check("stall_done_cycle", n, 811);
      tick();

      // Asynchronous reset mid-run, then a clean full run.
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      wait_for("reach_xr5", 5, 5, 9, n);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_phase", int'(phase), 0);
      check("arst_cnt", int'(cnt), 0);
      check("arst_round", int'(round), 0);
      check("arst_strobes", int'({shift_en, key_rd, wr_sel, mc_en, busy, done}), 0);
      tick();
      rst_n = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      run_to_done(n);
      check("post_reset_done_cycle", n, 806);
      tick();

      // Starts while busy are ignored.
      start = 1'b1;
      tick();
      start = 1'b0;
      dones = 0; done_at = -1;
      for (int c = 0; c < 1000; c++) begin
         start = (c == 100 || c == 805);
         if (done) begin
            dones++;
            if (done_at < 0) done_at = c;
         end
         tick();
      end
      start = 1'b0;
      check("busy_start_done_count", dones, 1);
      check("busy_start_done_cycle", done_at, 806);

      // Random start/stall traffic, checked by the per-cycle model compare.
      for (int c = 0; c < 4000; c++) begin
         start = ($urandom_range(0, 3) == 0);
         stall = ($urandom_range(0, 7) == 0);
         tick();
      end
      start = 1'b0;
      stall = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
